// File: rtl/hex_display_ctrl_pkg.sv
// Shared types and constants for the HEX display controller.
// Contains the blank segment pattern, the scheduler state enum and the digit index width.
package hex_disp_pkg;

    localparam int         DIGIT_W   = 3;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        COMMIT
    } stateT;

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Write channel from control logic into the HEX display controller.
// The master drives digit updates; the slave (the controller) returns ready and error.
interface hex_display_ctrl_if;
    import hex_disp_pkg::*;

    logic               wr_valid;
    logic               wr_ready;
    logic [DIGIT_W-1:0] wr_digit;
    logic [3:0]         wr_value;
    logic               wr_blank;
    logic               wr_err;

    modport master (
        output wr_valid, wr_digit, wr_value, wr_blank,
        input  wr_ready, wr_err
    );

    modport slave (
        input  wr_valid, wr_digit, wr_value, wr_blank,
        output wr_ready, wr_err
    );

endinterface

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to seven-segment decoder, active-low, bit order gfedcba.
module hex_seg_decoder
    import hex_disp_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// HEX digit owner: one shared decoder serves freshly written digits first, then periodic refresh.
// Optional blinking per digit is enabled with the HEX_DISPLAY_BLINK_EN macro.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 1024
`ifdef HEX_DISPLAY_BLINK_EN
    ,
    parameter int BLINK_DIV   = 25_000_000
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hex_display_ctrl_if.slave       bus,
`ifdef HEX_DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic                    busy,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int                 REF_W      = $clog2(REFRESH_DIV);
    localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_DIV - 1);
    localparam logic [REF_W-1:0]   REF_ONE    = REF_W'(1);
    localparam logic [DIGIT_W:0]   DIGITS_EXT = (DIGIT_W + 1)'(NUM_DIGITS);
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_ONE  = DIGIT_W'(1);

    stateT                         stateReg, stateNext;
    logic [DIGIT_W-1:0]            selReg, selNext;
    logic [DIGIT_W-1:0]            rrPtrReg, rrPtrNext;
    logic [DIGIT_W-1:0]            lowDirty;
    logic                          pendTake;

    logic [3:0]                    valueReg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]         blankReg;
    logic [NUM_DIGITS-1:0]         dirtyReg;
    logic [6:0]                    segQ;
    logic [6:0]                    decOut;
    logic [6:0]                    commitSeg;
    logic [NUM_DIGITS-1:0][6:0]    hexReg;
    logic                          errReg;

    logic [REF_W-1:0]              refreshCnt;
    logic                          refreshWrap;
    logic                          refreshPend;
    logic                          blinkToggle;

    logic                          wrAccept;
    logic                          wrInRange;

    // Ready simply tracks reset so writes are never stalled outside reset.
    assign bus.wr_ready = rst_n;
    assign bus.wr_err   = errReg;
    assign wrAccept     = bus.wr_valid & bus.wr_ready;
    assign wrInRange    = ({1'b0, bus.wr_digit} < DIGITS_EXT);
    assign busy         = (stateReg != IDLE) || (|dirtyReg);
    assign hex_out      = hexReg;

    hex_seg_decoder u_decoder (
        .value (valueReg[selReg]),
        .seg   (decOut)
    );

    // Scanning downward leaves the lowest dirty index as the winner.
    always_comb begin
        lowDirty = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (dirtyReg[i]) lowDirty = DIGIT_W'(i);
        end
    end

    always_comb begin
        stateNext = stateReg;
        selNext   = selReg;
        rrPtrNext = rrPtrReg;
        pendTake  = 1'b0;
        unique case (stateReg)
            IDLE: begin
                if (|dirtyReg) begin
                    selNext   = lowDirty;
                    stateNext = DECODE;
                end else if (refreshPend) begin
                    selNext   = rrPtrReg;
                    rrPtrNext = (rrPtrReg == LAST_DIGIT) ? '0 : rrPtrReg + DIGIT_ONE;
                    pendTake  = 1'b1;
                    stateNext = DECODE;
                end
            end
            DECODE:  stateNext = COMMIT;
            COMMIT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
            selReg   <= '0;
            rrPtrReg <= '0;
        end else begin
            stateReg <= stateNext;
            selReg   <= selNext;
            rrPtrReg <= rrPtrNext;
        end
    end

    // A write landing on sel during COMMIT re-sets dirty after the clear, so it is serviced again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blankReg <= '1;
            dirtyReg <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) valueReg[i] <= 4'h0;
        end else begin
            if (stateReg == COMMIT) dirtyReg[selReg] <= 1'b0;
            if (wrAccept && wrInRange) begin
                valueReg[bus.wr_digit] <= bus.wr_value;
                blankReg[bus.wr_digit] <= bus.wr_blank;
                dirtyReg[bus.wr_digit] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segQ   <= SEG_BLANK;
            hexReg <= '1;
            errReg <= 1'b0;
        end else begin
            errReg <= wrAccept & ~wrInRange;
            if (stateReg == DECODE) segQ <= blankReg[selReg] ? SEG_BLANK : decOut;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (stateReg == COMMIT && selReg == DIGIT_W'(i)) hexReg[i] <= commitSeg;
            end
        end
    end

    assign refreshWrap = (refreshCnt == REF_LAST);

    // Only one refresh can be outstanding; further wraps while pending are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refreshCnt  <= '0;
            refreshPend <= 1'b0;
        end else begin
            refreshCnt <= refreshWrap ? '0 : refreshCnt + REF_ONE;
            if (refreshWrap || blinkToggle) refreshPend <= 1'b1;
            else if (pendTake)              refreshPend <= 1'b0;
        end
    end

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int               BLINK_W    = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    logic [BLINK_W-1:0] blinkCnt;
    logic               blinkPhase;

    assign blinkToggle = (blinkCnt == BLINK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b1;
        end else begin
            blinkCnt <= blinkToggle ? '0 : blinkCnt + BLINK_ONE;
            if (blinkToggle) blinkPhase <= ~blinkPhase;
        end
    end

    assign commitSeg = (blink_mask[selReg] && !blinkPhase) ? SEG_BLANK : segQ;
`else
    assign blinkToggle = 1'b0;
    assign commitSeg   = segQ;
`endif

endmodule
